// File: rtl/basemul_acc.sv
// Kyber NTT-domain pointwise multiply-accumulate: K polynomial pairs are
// basemul'ed into a 2^(DEPTH-1)-entry accumulator, then drained as a stream.
module basemul_acc #(
    parameter int DEPTH = 8,
    parameter int K     = 3,
    parameter int Q     = 3329,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             tomont_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    dina_1,
    input  logic [DW-1:0]    dina_2,
    input  logic [DW-1:0]    dinb_1,
    input  logic [DW-1:0]    dinb_2,
    input  logic [DEPTH-1:0] in_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    dout_1,
    output logic [DW-1:0]    dout_2,
    output logic [DEPTH-1:0] out_index,
    output logic             busy,
    output logic             done
);
    localparam int PW   = DEPTH - 1;
    localparam int NP   = 1 << PW;
    localparam int L    = 3;
    localparam int KW   = (K > 1) ? $clog2(K) : 1;
    localparam int PWD  = 2 * DW;
    localparam int MONT = (1 << 16) % Q;
    localparam logic [PWD-1:0] QW = PWD'(Q);
    localparam logic [DW:0]    QD = (DW + 1)'(Q);

    // gamma_j = 17^(2*brv7(j)+1) mod Q, evaluated at elaboration
    function automatic int unsigned gamma_of(input int unsigned j);
        int unsigned br, e, r, b;
        br = 0;
        for (int i = 0; i < 7; i++) br |= ((j >> i) & 1) << (6 - i);
        e = 2 * br + 1;
        r = 1;
        b = 17 % Q;
        for (int i = 0; i < 8; i++) begin
            if (((e >> i) & 1) != 0) r = (r * b) % Q;
            b = (b * b) % Q;
        end
        return r;
    endfunction

    logic [DW-1:0] zeta_rom [128];
    for (genvar g = 0; g < 128; g++) begin : g_rom
        assign zeta_rom[g] = DW'(gamma_of(g));
    end

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;
    state_t state;

    logic [KW-1:0] kcnt;
    logic [PW-1:0] pcnt;
    logic [1:0]    bub, fcnt;
    logic          tm;
    logic [2:1]    vld_pipe;
    logic          acc;
    logic [6:0]    zj;
    logic          unused_bits;

    assign in_ready    = (state == ACCUM) && (bub == 2'd0);
    assign acc         = in_valid && in_ready;
    assign busy        = (state != IDLE);
    assign zj          = 7'(in_index[DEPTH-1:1]);
    assign unused_bits = in_index[0];

    // stage 1: raw products
    logic           s1_k0;
    logic [PW-1:0]  s1_idx;
    logic [PWD-1:0] s1_a0b0, s1_a1b1, s1_a0b1, s1_a1b0;
    logic [DW-1:0]  s1_g;
    // stage 2: reduced pair, buffer read data alongside
    logic           s2_k0;
    logic [PW-1:0]  s2_idx;
    logic [DW-1:0]  s2_p0, s2_p1;

    logic [PWD-1:0] t11, tg, p0, p1;
    always_comb begin
        t11 = s1_a1b1 % QW;
        tg  = (t11 * PWD'(s1_g)) % QW;
        p0  = (s1_a0b0 % QW) + tg;
        if (p0 >= QW) p0 = p0 - QW;
        p1  = (s1_a0b1 + s1_a1b0) % QW;
    end

    always_ff @(posedge clk) begin
        s1_k0   <= (kcnt == '0);
        s1_idx  <= in_index[DEPTH-1:1];
        s1_a0b0 <= PWD'(dina_1) * PWD'(dinb_1);
        s1_a1b1 <= PWD'(dina_2) * PWD'(dinb_2);
        s1_a0b1 <= PWD'(dina_1) * PWD'(dinb_2);
        s1_a1b0 <= PWD'(dina_2) * PWD'(dinb_1);
        s1_g    <= zeta_rom[zj];
        s2_k0   <= s1_k0;
        s2_idx  <= s1_idx;
        s2_p0   <= DW'(p0);
        s2_p1   <= DW'(p1);
    end

    // accumulator buffer, one sync read port shared by ACCUM and DRAIN
    logic [PWD-1:0] mem [NP];
    logic [PWD-1:0] rdata, wdata;
    logic [PW-1:0]  raddr, rd_addr;
    logic [DW:0]    sum0, sum1;

    assign raddr = (state == DRAIN) ? rd_addr : s1_idx;

    always_comb begin
        sum0 = {1'b0, rdata[DW-1:0]} + {1'b0, s2_p0};
        sum1 = {1'b0, rdata[PWD-1:DW]} + {1'b0, s2_p1};
        if (sum0 >= QD) sum0 = sum0 - QD;
        if (sum1 >= QD) sum1 = sum1 - QD;
        wdata = s2_k0 ? {s2_p1, s2_p0} : {DW'(sum1), DW'(sum0)};
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        if (vld_pipe[2] && !reset) mem[s2_idx] <= wdata;
    end

    // drain: read -> optional tomont -> 2-entry skid
    logic          rd_done, rd_vld, issue, pop;
    logic [2:0]    occ;
    logic [PWD-1:0] fifo_d [2];
    logic          wp, rp;
    logic [1:0]    cnt;
    logic [PW-1:0] out_cnt;
    logic [DW-1:0] mt0, mt1;

    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign occ       = 3'(cnt) + 3'(rd_vld);
    assign issue     = (state == DRAIN) && !rd_done && (occ < 3'd2 + 3'(pop));
    assign dout_1    = fifo_d[rp][DW-1:0];
    assign dout_2    = fifo_d[rp][PWD-1:DW];
    assign out_index = {out_cnt, 1'b0};

    always_comb begin
        mt0 = rdata[DW-1:0];
        mt1 = rdata[PWD-1:DW];
        if (tm) begin
            mt0 = DW'((PWD'(rdata[DW-1:0]) * PWD'(MONT)) % QW);
            mt1 = DW'((PWD'(rdata[PWD-1:DW]) * PWD'(MONT)) % QW);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            kcnt     <= '0;
            pcnt     <= '0;
            bub      <= '0;
            fcnt     <= '0;
            tm       <= 1'b0;
            vld_pipe <= '0;
            rd_addr  <= '0;
            rd_done  <= 1'b0;
            rd_vld   <= 1'b0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= '0;
            out_cnt  <= '0;
            done     <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_d[i] <= '0;
        end else begin
            done     <= 1'b0;
            vld_pipe <= {vld_pipe[1], acc};
            rd_vld   <= issue;
            cnt      <= cnt + 2'(rd_vld) - 2'(pop);
            if (issue) begin
                rd_addr <= rd_addr + 1'b1;
                if (rd_addr == PW'(NP - 1)) rd_done <= 1'b1;
            end
            if (rd_vld) begin
                fifo_d[wp] <= {mt1, mt0};
                wp         <= ~wp;
            end
            if (pop) begin
                rp      <= ~rp;
                out_cnt <= out_cnt + 1'b1;
            end
            case (state)
                IDLE: if (start && !done) begin
                    state   <= ACCUM;
                    tm      <= tomont_en;
                    kcnt    <= '0;
                    pcnt    <= '0;
                    bub     <= '0;
                    rd_addr <= '0;
                    rd_done <= 1'b0;
                    out_cnt <= '0;
                end
                ACCUM: begin
                    if (bub != 2'd0) bub <= bub - 1'b1;
                    if (acc) begin
                        if (pcnt == PW'(NP - 1)) begin
                            pcnt <= '0;
                            if (kcnt == KW'(K - 1)) begin
                                state <= FLUSH;
                                fcnt  <= 2'(L);
                            end else begin
                                // bubble keeps a reused index from reading before its write lands
                                kcnt <= kcnt + 1'b1;
                                bub  <= 2'(L);
                            end
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt - 1'b1;
                    if (fcnt == 2'd1) state <= DRAIN;
                end
                DRAIN: if (pop && out_cnt == PW'(NP - 1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_basemul_acc.sv
// Directed bench for basemul_acc: three instances (K=1,2,3) share clock/reset;
// expected outputs go into a scoreboard queue popped by per-instance monitors.
module tb_basemul_acc;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_s [3], tm_s [3], iv_s [3], or_s [3];
    logic [15:0] a1_s [3], a2_s [3], b1_s [3], b2_s [3];
    logic [7:0]  idx_s [3];
    logic        ir_s [3], ov_s [3], busy_s [3], done_s [3];
    logic [15:0] d1_s [3], d2_s [3];
    logic [7:0]  oi_s [3];
    bit          stall_en [3];
    int          done_cnt [3];
    int          exp_done [3];

    typedef struct { int u; int idx; int d1; int d2; } exp_t;
    exp_t sb_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    int pa0 [3][128], pa1 [3][128], pb0 [3][128], pb1 [3][128];
    int ex [256];
    bit rev [3];

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_u
        basemul_acc #(.DEPTH(8), .K(g + 1), .Q(3329), .DW(16)) dut (
            .clk(clk), .reset(reset), .start(start_s[g]), .tomont_en(tm_s[g]),
            .in_valid(iv_s[g]), .in_ready(ir_s[g]),
            .dina_1(a1_s[g]), .dina_2(a2_s[g]), .dinb_1(b1_s[g]), .dinb_2(b2_s[g]),
            .in_index(idx_s[g]), .out_valid(ov_s[g]), .out_ready(or_s[g]),
            .dout_1(d1_s[g]), .dout_2(d2_s[g]), .out_index(oi_s[g]),
            .busy(busy_s[g]), .done(done_s[g])
        );

        always @(posedge clk) begin
            #1;
            or_s[g] = stall_en[g] ? 1'($urandom_range(0, 1)) : 1'b1;
        end

        logic [15:0] hold_d1;
        logic [7:0]  hold_oi;
        bit          held;
        always @(negedge clk) begin : mon
            exp_t e;
            if (reset) begin
                held = 1'b0;
            end else begin
                if (held && ov_s[g]) begin
                    chk("stall_hold_data", int'(d1_s[g]), int'(hold_d1));
                    chk("stall_hold_index", int'(oi_s[g]), int'(hold_oi));
                end
                held    = ov_s[g] && !or_s[g];
                hold_d1 = d1_s[g];
                hold_oi = oi_s[g];
                if (ov_s[g] && or_s[g]) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: unit %0d index %0d, want none", g, oi_s[g]);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_unit", g, e.u);
                        chk("out_index", int'(oi_s[g]), e.idx);
                        chk("dout_1", int'(d1_s[g]), e.d1);
                        chk("dout_2", int'(d2_s[g]), e.d2);
                    end
                end
                if (done_s[g]) done_cnt[g]++;
            end
        end
    end

    task automatic clear_vec();
        for (int k = 0; k < 3; k++) begin
            rev[k] = 1'b0;
            for (int j = 0; j < 128; j++) begin
                pa0[k][j] = 0; pa1[k][j] = 0; pb0[k][j] = 0; pb1[k][j] = 0;
            end
        end
        for (int i = 0; i < 256; i++) ex[i] = 0;
    endtask

    task automatic feed(input int u, input int npoly, input int stop_k, input int stop_n);
        int j, waits, extra;
        bit stop;
        stop = 1'b0;
        for (int k = 0; k < npoly && !stop; k++) begin
            extra = 0;
            for (int n = 0; n < 128 && !stop; n++) begin
                j = rev[k] ? 127 - n : n;
                iv_s[u]  = 1'b1;
                a1_s[u]  = 16'(pa0[k][j]);
                a2_s[u]  = 16'(pa1[k][j]);
                b1_s[u]  = 16'(pb0[k][j]);
                b2_s[u]  = 16'(pb1[k][j]);
                idx_s[u] = 8'(2 * j);
                waits = 0;
                while (1) begin
                    @(negedge clk);
                    if (ir_s[u]) break;
                    waits++;
                    if (waits > 20) begin
                        n_bad++;
                        $display("FAIL in_ready_timeout: unit %0d poly %0d pair %0d", u, k, n);
                        $fatal(1, "in_ready stuck low");
                    end
                end
                @(posedge clk);
                #1;
                if (n == 0 && k == 0) chk("first_ready_wait", waits, 0);
                else if (n == 0) chk("poly_bubble", waits, 3);
                else extra += waits;
                if (k == stop_k && n == stop_n) stop = 1'b1;
            end
            if (!stop) chk("midpoly_stall", extra, 0);
        end
        iv_s[u] = 1'b0;
    endtask

    task automatic run(input int u, input bit tm, input int npoly);
        int got;
        tm_s[u]    = tm;
        start_s[u] = 1'b1;
        @(posedge clk);
        #1;
        start_s[u] = 1'b0;
        tm_s[u]    = !tm;  // late changes must not affect this run
        chk("busy_after_start", int'(busy_s[u]), 1);
        chk("ready_after_start", int'(ir_s[u]), 1);
        feed(u, npoly, -1, -1);
        for (int i = 0; i < 128; i++) sb_q.push_back('{u, 2 * i, ex[2 * i], ex[2 * i + 1]});
        got = 0;
        for (int c = 0; c < 4000 && got == 0; c++) begin
            @(negedge clk);
            if (done_s[u]) got = 1;
        end
        chk("done_seen", got, 1);
        if (got != 0) chk("busy_low_with_done", int'(busy_s[u]), 0);
        start_s[u] = 1'b1;  // coincides with done: must be ignored
        @(posedge clk);
        #1;
        start_s[u] = 1'b0;
        @(negedge clk);
        chk("start_on_done_ignored", int'(busy_s[u]), 0);
        chk("done_one_cycle", int'(done_s[u]), 0);
        chk("sb_drained", sb_q.size(), 0);
        exp_done[u]++;
        chk("done_count", done_cnt[u], exp_done[u]);
    endtask

    task automatic chk_idle(input int u);
        chk("rst_in_ready", int'(ir_s[u]), 0);
        chk("rst_out_valid", int'(ov_s[u]), 0);
        chk("rst_dout_1", int'(d1_s[u]), 0);
        chk("rst_dout_2", int'(d2_s[u]), 0);
        chk("rst_out_index", int'(oi_s[u]), 0);
        chk("rst_busy", int'(busy_s[u]), 0);
        chk("rst_done", int'(done_s[u]), 0);
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            start_s[u] = 1'b0; tm_s[u] = 1'b0; iv_s[u] = 1'b0;
            a1_s[u] = '0; a2_s[u] = '0; b1_s[u] = '0; b2_s[u] = '0; idx_s[u] = '0;
            stall_en[u] = 1'b0; done_cnt[u] = 0; exp_done[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_idle(0);

        // K=1: a=b=(1,0) at pair 0
        clear_vec();
        pa0[0][0] = 1; pb0[0][0] = 1;
        ex[0] = 1;
        run(0, 1'b0, 1);

        // K=1: a=b=(0,1) at index 0 and 2 -> gamma_0, gamma_1
        clear_vec();
        pa1[0][0] = 1; pb1[0][0] = 1; pa1[0][1] = 1; pb1[0][1] = 1;
        ex[0] = 17; ex[2] = 3312;
        run(0, 1'b0, 1);

        // K=1: every term wraps, (Q-1)^2 = 1
        clear_vec();
        pa0[0][0] = 3328; pa1[0][0] = 3328; pb0[0][0] = 3328; pb1[0][0] = 3328;
        ex[0] = 18; ex[1] = 2;
        run(0, 1'b0, 1);

        // K=3: all pairs (1,0), polynomial 1 reversed
        clear_vec();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 128; j++) begin
                pa0[k][j] = 1; pb0[k][j] = 1;
            end
        rev[1] = 1'b1;
        for (int j = 0; j < 128; j++) ex[2 * j] = 3;
        run(2, 1'b0, 3);

        // K=2, tomont: 2*2285 mod 3329, random output stalls
        clear_vec();
        pa0[0][0] = 1; pb0[0][0] = 1; pa0[1][0] = 1; pb0[1][0] = 1;
        ex[0] = 1241;
        stall_en[1] = 1'b1;
        run(1, 1'b1, 2);
        stall_en[1] = 1'b0;

        // abort mid-ACCUM (poly 1, pair 40), then a fresh run
        clear_vec();
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 128; j++) begin
                pa0[k][j] = 1; pb0[k][j] = 1;
            end
        tm_s[1] = 1'b0;
        start_s[1] = 1'b1;
        @(posedge clk);
        #1;
        start_s[1] = 1'b0;
        feed(1, 2, 1, 40);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_idle(1);
        chk("abort_no_done", done_cnt[1], exp_done[1]);
        clear_vec();
        pa0[0][0] = 1; pb0[0][0] = 1;
        ex[0] = 1;
        run(1, 1'b0, 2);

        chk("unit0_runs", done_cnt[0], 3);
        chk("unit2_runs", done_cnt[2], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
